// File: rtl/lb_pkg.sv
// Shared types and helpers for the multi-flux line buffer.
package lb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WORK = 1'b1
    } state_e;

    localparam int unsigned FL_STORED = 0;
    localparam int unsigned FL_ZERO   = 1;
    localparam int unsigned FL_PASS   = 2;

    function automatic int unsigned tag_width(input int unsigned flux);
        return (flux > 1) ? $clog2(flux) : 1;
    endfunction

endpackage

// File: rtl/lb_line_mem.sv
// One flux's line store: flop array, asynchronous read, synchronous write.
module lb_line_mem #(
    parameter int unsigned DATA_W = 18,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Reads see the pre-write value when read and write hit the same entry.
    assign rdata = mem_q[raddr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/line_buffer_rr.sv
// Multi-flux single-line delay: round-robin arbiter, per-flux block counters and FSM.
module line_buffer_rr
    import lb_pkg::*;
#(
    parameter int unsigned FLUX       = 2,
    parameter int unsigned DATA_W     = 18,
    parameter int unsigned MAX_LEN    = 64,
    parameter int unsigned SIZE_W     = 7,
    parameter int unsigned FIRST_LINE = 0,
    localparam int unsigned TAG_W     = tag_width(FLUX)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [FLUX-1:0][TAG_W+DATA_W-1:0] read_port_in_pel_dout,
    input  logic [FLUX-1:0]                   read_port_in_pel_empty,
    output logic [FLUX-1:0]                   read_port_in_pel_read,
    input  logic [FLUX-1:0][TAG_W+SIZE_W-1:0] read_port_ext_size_dout,
    input  logic [FLUX-1:0]                   read_port_ext_size_empty,
    output logic [FLUX-1:0]                   read_port_ext_size_read,
    input  logic [FLUX-1:0][TAG_W+SIZE_W-1:0] read_port_real_size_dout,
    input  logic [FLUX-1:0]                   read_port_real_size_empty,
    output logic [FLUX-1:0]                   read_port_real_size_read,
    output logic [TAG_W+DATA_W-1:0]           write_port_out_pel_din,
    input  logic [FLUX-1:0]                   write_port_out_pel_full,
    output logic                              write_port_out_pel_write,
    output logic [FLUX-1:0]                   cfg_err
);

    localparam int unsigned CNT_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    state_e            state_q [FLUX];
    state_e            state_d [FLUX];
    logic [CNT_W-1:0]  cnt_h_q [FLUX];
    logic [CNT_W-1:0]  cnt_h_d [FLUX];
    logic [CNT_W-1:0]  max_h_q [FLUX];
    logic [CNT_W-1:0]  max_h_d [FLUX];
    logic [SIZE_W-1:0] cnt_v_q [FLUX];
    logic [SIZE_W-1:0] cnt_v_d [FLUX];
    logic [SIZE_W-1:0] max_v_q [FLUX];
    logic [SIZE_W-1:0] max_v_d [FLUX];
    logic [DATA_W-1:0] rd_data [FLUX];

    logic [TAG_W-1:0]  rr_ptr_q, rr_ptr_d, tag, cand;
    logic              fire;
    logic [FLUX-1:0]   elig, mem_we;
    logic [SIZE_W-1:0] ext_v, real_v;
    logic [DATA_W-1:0] pel_data, out_val;
    logic              unused_tags;

    always_comb begin
        unused_tags = 1'b0;
        for (int f = 0; f < FLUX; f++) begin
            elig[f] = (state_q[f] == IDLE)
                    ? (!read_port_ext_size_empty[f] && !read_port_real_size_empty[f])
                    : (!read_port_in_pel_empty[f] && !write_port_out_pel_full[f]);
            unused_tags = unused_tags
                        ^ (^read_port_in_pel_dout[f][TAG_W+DATA_W-1:DATA_W])
                        ^ (^read_port_ext_size_dout[f][TAG_W+SIZE_W-1:SIZE_W])
                        ^ (^read_port_real_size_dout[f][TAG_W+SIZE_W-1:SIZE_W]);
        end
    end

    // Scan downward so the candidate closest to rr_ptr is written last and wins.
    always_comb begin
        fire = 1'b0;
        tag  = '0;
        cand = '0;
        for (int i = FLUX - 1; i >= 0; i--) begin
            cand = TAG_W'((int'(rr_ptr_q) + i) % FLUX);
            if (elig[cand]) begin
                fire = 1'b1;
                tag  = cand;
            end
        end
        rr_ptr_d = fire ? TAG_W'((int'(tag) + 1) % FLUX) : rr_ptr_q;
    end

    always_comb begin
        for (int f = 0; f < FLUX; f++) begin
            state_d[f] = state_q[f];
            cnt_h_d[f] = cnt_h_q[f];
            cnt_v_d[f] = cnt_v_q[f];
            max_h_d[f] = max_h_q[f];
            max_v_d[f] = max_v_q[f];
        end
        read_port_in_pel_read    = '0;
        read_port_ext_size_read  = '0;
        read_port_real_size_read = '0;
        write_port_out_pel_write = 1'b0;
        cfg_err                  = '0;
        mem_we                   = '0;
        ext_v                    = '0;
        real_v                   = '0;
        pel_data                 = '0;
        out_val                  = '0;

        if (fire && !rst) begin
            if (state_q[tag] == IDLE) begin
                ext_v = read_port_ext_size_dout[tag][SIZE_W-1:0];
                real_v = read_port_real_size_dout[tag][SIZE_W-1:0];
                read_port_ext_size_read[tag]  = 1'b1;
                read_port_real_size_read[tag] = 1'b1;
                if (ext_v == '0 || real_v == '0) begin
                    cfg_err[tag] = 1'b1;
                end else begin
                    if (32'(real_v) > MAX_LEN) begin
                        cfg_err[tag]   = 1'b1;
                        max_h_d[tag]   = CNT_W'(MAX_LEN - 1);
                    end else begin
                        max_h_d[tag]   = CNT_W'(32'(real_v) - 32'd1);
                    end
                    max_v_d[tag] = ext_v;
                    cnt_h_d[tag] = '0;
                    cnt_v_d[tag] = '0;
                    state_d[tag] = WORK;
                end
            end else begin
                pel_data = read_port_in_pel_dout[tag][DATA_W-1:0];
                read_port_in_pel_read[tag] = 1'b1;
                write_port_out_pel_write   = 1'b1;
                mem_we[tag]                = 1'b1;
                if (cnt_v_q[tag] != '0 || FIRST_LINE == FL_STORED) begin
                    out_val = rd_data[tag];
                end else if (FIRST_LINE == FL_PASS) begin
                    out_val = pel_data;
                end else begin
                    out_val = '0;
                end
                if (cnt_h_q[tag] < max_h_q[tag]) begin
                    cnt_h_d[tag] = cnt_h_q[tag] + 1'b1;
                end else if (cnt_v_q[tag] < max_v_q[tag] - 1'b1) begin
                    cnt_h_d[tag] = '0;
                    cnt_v_d[tag] = cnt_v_q[tag] + 1'b1;
                end else begin
                    cnt_h_d[tag] = '0;
                    cnt_v_d[tag] = '0;
                    state_d[tag] = IDLE;
                end
            end
        end
    end

    assign write_port_out_pel_din = write_port_out_pel_write ? {tag, out_val} : '0;

    for (genvar g = 0; g < FLUX; g++) begin : g_mem
        lb_line_mem #(
            .DATA_W (DATA_W),
            .DEPTH  (MAX_LEN),
            .ADDR_W (CNT_W)
        ) u_mem (
            .clk   (clk),
            .rst   (rst),
            .we    (mem_we[g]),
            .waddr (cnt_h_q[g]),
            .wdata (read_port_in_pel_dout[g][DATA_W-1:0]),
            .raddr (cnt_h_q[g]),
            .rdata (rd_data[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            for (int f = 0; f < FLUX; f++) begin
                state_q[f] <= IDLE;
                cnt_h_q[f] <= '0;
                cnt_v_q[f] <= '0;
                max_h_q[f] <= '0;
                max_v_q[f] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            state_q  <= state_d;
            cnt_h_q  <= cnt_h_d;
            cnt_v_q  <= cnt_v_d;
            max_h_q  <= max_h_d;
            max_v_q  <= max_v_d;
        end
    end

endmodule

// File: tb/tb_line_buffer_rr.sv
// Scoreboard bench: two instances (stored / pass-through first line) share one set of FIFOs.
module tb_line_buffer_rr;

    localparam int FLUX = 2;
    localparam int DW   = 18;
    localparam int SW   = 7;
    localparam int TW   = 1;
    localparam int ML   = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [FLUX-1:0][TW+DW-1:0] pel_dout;
    logic [FLUX-1:0][TW+SW-1:0] ext_dout, real_dout;
    logic [FLUX-1:0]            pel_empty, ext_empty, real_empty, full;
    logic [FLUX-1:0]            d0_rd_pel, d0_rd_ext, d0_rd_real, d0_cfg;
    logic [FLUX-1:0]            d2_rd_pel, d2_rd_ext, d2_rd_real, d2_cfg;
    logic [TW+DW-1:0]           d0_din, d2_din;
    logic                       d0_wr, d2_wr;

    line_buffer_rr #(.FLUX(FLUX), .DATA_W(DW), .MAX_LEN(ML), .SIZE_W(SW), .FIRST_LINE(0)) dut0 (
        .clk(clk), .rst(rst),
        .read_port_in_pel_dout(pel_dout), .read_port_in_pel_empty(pel_empty),
        .read_port_in_pel_read(d0_rd_pel),
        .read_port_ext_size_dout(ext_dout), .read_port_ext_size_empty(ext_empty),
        .read_port_ext_size_read(d0_rd_ext),
        .read_port_real_size_dout(real_dout), .read_port_real_size_empty(real_empty),
        .read_port_real_size_read(d0_rd_real),
        .write_port_out_pel_din(d0_din), .write_port_out_pel_full(full),
        .write_port_out_pel_write(d0_wr), .cfg_err(d0_cfg)
    );

    line_buffer_rr #(.FLUX(FLUX), .DATA_W(DW), .MAX_LEN(ML), .SIZE_W(SW), .FIRST_LINE(2)) dut2 (
        .clk(clk), .rst(rst),
        .read_port_in_pel_dout(pel_dout), .read_port_in_pel_empty(pel_empty),
        .read_port_in_pel_read(d2_rd_pel),
        .read_port_ext_size_dout(ext_dout), .read_port_ext_size_empty(ext_empty),
        .read_port_ext_size_read(d2_rd_ext),
        .read_port_real_size_dout(real_dout), .read_port_real_size_empty(real_empty),
        .read_port_real_size_read(d2_rd_real),
        .write_port_out_pel_din(d2_din), .write_port_out_pel_full(full),
        .write_port_out_pel_write(d2_wr), .cfg_err(d2_cfg)
    );

    int unsigned pel_q [FLUX][$];
    int unsigned ext_q [FLUX][$];
    int unsigned real_q[FLUX][$];
    int unsigned exp0_q[FLUX][$];
    int unsigned exp2_q[FLUX][$];
    int unsigned ref_buf[FLUX][ML];
    int          cfg_exp[FLUX];
    int          cfg_seen0[FLUX];
    int          cfg_seen2[FLUX];
    int          ext_rd_cnt[FLUX];
    int          wr_cnt[FLUX];
    int          tag_log[$];
    bit          log_en = 1'b0;
    logic [FLUX-1:0] rl_pel, rl_ext, rl_real;
    logic [TW-1:0]   t0, t2;
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nm, input longint unsigned act, input longint unsigned req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    // Tag bits carry a deliberately wrong value; the DUT must use the port index.
    task automatic update_inputs();
        for (int f = 0; f < FLUX; f++) begin
            pel_empty[f]  = (pel_q[f].size() == 0);
            ext_empty[f]  = (ext_q[f].size() == 0);
            real_empty[f] = (real_q[f].size() == 0);
            pel_dout[f]  = {TW'(f + 1), (pel_q[f].size() != 0) ? DW'(pel_q[f][0]) : DW'(0)};
            ext_dout[f]  = {TW'(f + 1), (ext_q[f].size() != 0) ? SW'(ext_q[f][0]) : SW'(0)};
            real_dout[f] = {TW'(f + 1), (real_q[f].size() != 0) ? SW'(real_q[f][0]) : SW'(0)};
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_sizes(input int f, input int ext, input int rl);
        ext_q[f].push_back(ext);
        real_q[f].push_back(rl);
        if (ext == 0 || rl == 0 || rl > ML) cfg_exp[f]++;
        update_inputs();
    endtask

    // Reference line-delay model; count limits how many pixels are issued.
    task automatic push_pixels(input int f, input int ext, input int rl, input int base,
                               input int count);
        int n = 0;
        int len = (rl > ML) ? ML : rl;
        for (int v = 0; v < ext; v++) begin
            for (int h = 0; h < len; h++) begin
                if (n < count) begin
                    int unsigned pix = base + n;
                    pel_q[f].push_back(pix);
                    exp0_q[f].push_back(ref_buf[f][h]);
                    exp2_q[f].push_back((v == 0) ? pix : ref_buf[f][h]);
                    ref_buf[f][h] = pix;
                    n++;
                end
            end
        end
        update_inputs();
    endtask

    task automatic push_block(input int f, input int ext, input int rl, input int base);
        push_sizes(f, ext, rl);
        if (ext != 0 && rl != 0) push_pixels(f, ext, rl, base, 1 << 20);
    endtask

    task automatic wait_drain(input string nm, input int budget);
        int left = 0;
        for (int c = 0; c < budget; c++) begin
            left = 0;
            for (int f = 0; f < FLUX; f++) begin
                left += pel_q[f].size() + ext_q[f].size() + exp0_q[f].size() + exp2_q[f].size();
            end
            if (left == 0) break;
            tick(1);
        end
        check(nm, left, 0);
    endtask

    // FIFO model: pop what the stored-mode DUT read in the cycle just ended.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int f = 0; f < FLUX; f++) begin
                if (rl_pel[f] && pel_q[f].size() != 0) void'(pel_q[f].pop_front());
                if (rl_ext[f] && ext_q[f].size() != 0) void'(ext_q[f].pop_front());
                if (rl_real[f] && real_q[f].size() != 0) void'(real_q[f].pop_front());
            end
            update_inputs();
        end
    end

    // Monitor: samples at negedge, pops the scoreboard per tag.
    initial begin
        forever begin
            @(negedge clk);
            rl_pel  = d0_rd_pel;
            rl_ext  = d0_rd_ext;
            rl_real = d0_rd_real;
            if (rst) begin
                check("rst_quiet_d0", {d0_wr, d0_rd_pel, d0_rd_ext, d0_rd_real, d0_cfg}, 0);
                check("rst_quiet_d2", {d2_wr, d2_rd_pel, d2_rd_ext, d2_rd_real, d2_cfg}, 0);
            end else begin
                for (int f = 0; f < FLUX; f++) begin
                    if (d0_cfg[f]) cfg_seen0[f]++;
                    if (d2_cfg[f]) cfg_seen2[f]++;
                    if (d0_rd_ext[f]) ext_rd_cnt[f]++;
                    if (full[f]) check($sformatf("rd_while_full_f%0d", f), d0_rd_pel[f], 0);
                end
                if (d0_wr) begin
                    t0 = d0_din[TW+DW-1 -: TW];
                    wr_cnt[t0]++;
                    if (log_en) tag_log.push_back(int'(t0));
                    check("d0_wr_while_full", full[t0], 0);
                    check("d0_tag_read_match", d0_rd_pel[t0], 1);
                    if (exp0_q[t0].size() == 0) check("d0_unexpected_out", 1, 0);
                    else check($sformatf("d0_data_f%0d", t0), d0_din[DW-1:0],
                               exp0_q[t0].pop_front());
                end
                if (d2_wr) begin
                    t2 = d2_din[TW+DW-1 -: TW];
                    if (exp2_q[t2].size() == 0) check("d2_unexpected_out", 1, 0);
                    else check($sformatf("d2_data_f%0d", t2), d2_din[DW-1:0],
                               exp2_q[t2].pop_front());
                end
            end
        end
    end

    int unsigned p1[12]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12};
    int unsigned e10[12] = '{0, 0, 0, 0, 1, 2, 3, 4, 5, 6, 7, 8};
    int unsigned e12[12] = '{1, 2, 3, 4, 1, 2, 3, 4, 5, 6, 7, 8};
    int w0, w1, er;

    initial begin
        full = '0;
        for (int f = 0; f < FLUX; f++) begin
            cfg_exp[f] = 0; cfg_seen0[f] = 0; cfg_seen2[f] = 0;
            ext_rd_cnt[f] = 0; wr_cnt[f] = 0;
            for (int h = 0; h < ML; h++) ref_buf[f][h] = 0;
        end
        rl_pel = '0; rl_ext = '0; rl_real = '0;
        update_inputs();
        tick(3);
        rst = 1'b0;
        tick(2);
        check("idle_no_write", wr_cnt[0] + wr_cnt[1], 0);

        // Single flux 3x4 block with hand-computed outputs.
        push_sizes(0, 3, 4);
        for (int i = 0; i < 12; i++) begin
            pel_q[0].push_back(p1[i]);
            exp0_q[0].push_back(e10[i]);
            exp2_q[0].push_back(e12[i]);
        end
        for (int h = 0; h < 4; h++) ref_buf[0][h] = 9 + h;
        update_inputs();
        wait_drain("drain_basic", 100);

        // Back in IDLE: fresh sizes are consumed with no pixels queued.
        er = ext_rd_cnt[0];
        push_sizes(0, 1, 4);
        tick(4);
        check("idle_after_block", ext_rd_cnt[0] - er, 1);
        push_pixels(0, 1, 4, 21, 4);
        wait_drain("drain_second", 100);

        // Both fluxes eligible: grants must alternate.
        tag_log.delete();
        log_en = 1'b1;
        push_block(0, 2, 4, 100);
        push_block(1, 2, 4, 200);
        wait_drain("drain_rr", 200);
        log_en = 1'b0;
        check("rr_log_len", tag_log.size(), 16);
        for (int i = 1; i < tag_log.size(); i++) begin
            check($sformatf("rr_alternate_%0d", i), tag_log[i] != tag_log[i-1], 1);
        end

        // Back-pressure on flux 0 only.
        push_block(0, 2, 8, 300);
        push_block(1, 3, 8, 400);
        tick(6);
        w0 = wr_cnt[0];
        w1 = wr_cnt[1];
        full[0] = 1'b1;
        tick(5);
        full[0] = 1'b0;
        check("stall_f0_writes", wr_cnt[0] - w0, 0);
        check("stream_f1_writes", wr_cnt[1] - w1, 5);
        wait_drain("drain_stall", 300);

        // Oversized line clamps to MAX_LEN; zero sizes are rejected.
        push_block(0, 2, 100, 500);
        wait_drain("drain_clamp", 400);
        push_block(1, 0, 4, 0);
        push_block(0, 2, 0, 0);
        tick(4);
        push_block(1, 1, 4, 600);
        wait_drain("drain_after_err", 100);
        for (int f = 0; f < FLUX; f++) begin
            check($sformatf("cfg_err_d0_f%0d", f), cfg_seen0[f], cfg_exp[f]);
            check($sformatf("cfg_err_d2_f%0d", f), cfg_seen2[f], cfg_exp[f]);
        end

        // Reset mid-block at column 2 of the second line.
        push_sizes(0, 2, 4);
        push_pixels(0, 2, 4, 700, 6);
        wait_drain("drain_partial", 100);
        tick(1);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        for (int f = 0; f < FLUX; f++) begin
            for (int h = 0; h < ML; h++) ref_buf[f][h] = 0;
        end
        push_block(0, 2, 4, 800);
        wait_drain("drain_post_rst", 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
